// File: rtl/vend_buyer.sv
// vend_buyer: customer-side coin/button agent for the vending machine.
// Inserts coins, settles over-pay change, presses, then collects returns.
module vend_buyer #(
  parameter int PRICE   = 10,
  parameter int TIMEOUT = 32,
  parameter int QUIET   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num1,
  input  logic [2:0] num5,
  output logic [1:0] InCoin,
  output logic       Button,
  input  logic       Can,
  input  logic       OutCoin,
  output logic       busy,
  output logic       done,
  output logic       got_can,
  output logic [4:0] change_cnt,
  output logic [3:0] left1,
  output logic [2:0] left5,
  output logic       err_short,
  output logic       err_tmo
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int QW = $clog2(QUIET + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [QW-1:0] QLAST = QW'(QUIET - 1);
  localparam logic [4:0] PRICE_C = 5'(PRICE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSERT,
    S_SETTLE,
    S_PRESS,
    S_WAIT,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [1:0] in_coin_q, in_coin_d;
  logic button_q, button_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic got_can_q, got_can_d;
  logic [4:0] chg_q, chg_d;
  logic [3:0] left1_q, left1_d;
  logic [2:0] left5_q, left5_d;
  logic [4:0] credit_q, credit_d;
  logic [4:0] exp_q, exp_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic err_short_q, err_short_d;
  logic err_tmo_q, err_tmo_d;

  logic [4:0] chg_inc;
  logic has1, has5, none;

  assign chg_inc = (chg_q == 5'd31) ? chg_q : chg_q + 5'd1;
  assign has1 = |left1_q;
  assign has5 = ~has1 & (|left5_q);
  assign none = ~has1 & ~(|left5_q);

  always_comb begin
    state_d     = state_q;
    in_coin_d   = 2'b00;
    button_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    got_can_d   = got_can_q;
    chg_d       = chg_q;
    left1_d     = left1_q;
    left5_d     = left5_q;
    credit_d    = credit_q;
    exp_d       = exp_q;
    tmo_d       = tmo_q;
    qcnt_d      = qcnt_q;
    err_short_d = err_short_q;
    err_tmo_d   = err_tmo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          left1_d     = num1;
          left5_d     = num5;
          credit_d    = 5'd0;
          chg_d       = 5'd0;
          got_can_d   = 1'b0;
          err_short_d = 1'b0;
          err_tmo_d   = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_INSERT;
        end
      end
      S_INSERT: begin
        unique case (1'b1)
          has1: begin
            in_coin_d = 2'b01;
            left1_d   = left1_q - 4'd1;
            credit_d  = credit_q + 5'd1;
          end
          has5: begin
            in_coin_d = 2'b10;
            left5_d   = left5_q - 3'd1;
            credit_d  = credit_q + 5'd5;
          end
          none: begin
            err_short_d = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end
          default: ;
        endcase
        // the coin just chosen is the last one if it reaches the price
        if (in_coin_d != 2'b00 && credit_d >= PRICE_C) begin
          exp_d   = credit_d - PRICE_C;
          tmo_d   = TMO_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (exp_q == 5'd0) begin
          button_d = 1'b1;
          state_d  = S_PRESS;
        end else if (OutCoin) begin
          chg_d = chg_inc;
          exp_d = exp_q - 5'd1;
          tmo_d = TMO_LOAD;
          if (exp_q == 5'd1) begin
            button_d = 1'b1;
            state_d  = S_PRESS;
          end
        end else if (tmo_q == '0) begin
          err_tmo_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_PRESS: begin
        tmo_d   = TMO_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Can) begin
          got_can_d = 1'b1;
          if (OutCoin) chg_d = chg_inc;
          qcnt_d  = '0;
          state_d = S_COLLECT;
        end else if (tmo_q == '0) begin
          err_tmo_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_COLLECT: begin
        if (OutCoin) begin
          chg_d  = chg_inc;
          qcnt_d = '0;
        end else if (qcnt_q == QLAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_coin_q   <= 2'b00;
      button_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      got_can_q   <= 1'b0;
      chg_q       <= 5'd0;
      left1_q     <= 4'd0;
      left5_q     <= 3'd0;
      credit_q    <= 5'd0;
      exp_q       <= 5'd0;
      tmo_q       <= '0;
      qcnt_q      <= '0;
      err_short_q <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_coin_q   <= in_coin_d;
      button_q    <= button_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      got_can_q   <= got_can_d;
      chg_q       <= chg_d;
      left1_q     <= left1_d;
      left5_q     <= left5_d;
      credit_q    <= credit_d;
      exp_q       <= exp_d;
      tmo_q       <= tmo_d;
      qcnt_q      <= qcnt_d;
      err_short_q <= err_short_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign InCoin     = in_coin_q;
  assign Button     = button_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign got_can    = got_can_q;
  assign change_cnt = chg_q;
  assign left1      = left1_q;
  assign left5      = left5_q;
  assign err_short  = err_short_q;
  assign err_tmo    = err_tmo_q;

endmodule
